// File: rtl/conf_int_add_share_ctrl.sv
// Round-robin front end that time-shares one configurable integer adder between NUM_REQ requesters.
// Operands and mode are registered toward the adder; results return on a tagged valid/ready port.
module conf_int_add_share_ctrl #(
    parameter int NUM_REQ            = 4,
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int OP_BITWIDTH        = 16,
    parameter int CNT_W              = 16,
    localparam int DW                = DATA_PATH_BITWIDTH,
    localparam int IDW               = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_acc,
    output logic [DW-1:0]         add_a,
    output logic [DW-1:0]         add_b,
    output logic                  add_acc_sel,
    input  logic [DW:0]           add_d,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [DW:0]           rsp_d,
    output logic                  rsp_acc,
    output logic [CNT_W-1:0]      cnt_acc,
    output logic [CNT_W-1:0]      cnt_apx
);

    // state  | meaning
    // IDLE   | waiting for a request; the only state that can grant
    // SETTLE | one cycle for the adder to switch accuracy mode
    // EXEC   | adder output captured into rsp_d, statistics updated
    // RESP   | response held until rsp_ready
    typedef enum logic [1:0] {IDLE, SETTLE, EXEC, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand;
    logic           gnt_found;
    logic           pending_acc;
    logic           unused_op_width;

    // The adder width parameter only matters to the adder instance itself.
    assign unused_op_width = (OP_BITWIDTH > 0);

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_REQ;
        return IDW'(s);
    endfunction

    // Search starts just past the previous winner, so every grant moves priority on.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = wrap_add(last_grant, k);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_grant  <= IDW'(NUM_REQ - 1);
            add_a       <= '0;
            add_b       <= '0;
            add_acc_sel <= 1'b1;
            pending_acc <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_d       <= '0;
            rsp_acc     <= 1'b0;
            cnt_acc     <= '0;
            cnt_apx     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_found) begin
                        add_a       <= req_a[gnt_idx*DW +: DW];
                        add_b       <= req_b[gnt_idx*DW +: DW];
                        pending_acc <= req_acc[gnt_idx];
                        rsp_id      <= gnt_idx;
                        last_grant  <= gnt_idx;
                        state       <= (req_acc[gnt_idx] != add_acc_sel) ? SETTLE : EXEC;
                    end
                end
                SETTLE: begin
                    add_acc_sel <= pending_acc;
                    state       <= EXEC;
                end
                EXEC: begin
                    rsp_d     <= add_d;
                    rsp_acc   <= add_acc_sel;
                    rsp_valid <= 1'b1;
                    if (add_acc_sel) begin
                        if (cnt_acc != '1) cnt_acc <= cnt_acc + CNT_W'(1);
                    end else begin
                        if (cnt_apx != '1) cnt_apx <= cnt_apx + CNT_W'(1);
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conf_int_add_share_ctrl.sv
// Scoreboard bench for conf_int_add_share_ctrl with a behavioural adder and round-robin model.
// Narrow statistics counters let saturation be reached in a short run.
module tb_conf_int_add_share_ctrl;
    localparam int NR   = 4;
    localparam int DW   = 16;
    localparam int CW   = 5;
    localparam int IDW  = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid, req_ready, req_acc;
    logic [NR*DW-1:0]  req_a, req_b;
    logic [DW-1:0]     add_a, add_b;
    logic              add_acc_sel;
    logic [DW:0]       add_d;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [DW:0]       rsp_d;
    logic              rsp_acc;
    logic [CW-1:0]     cnt_acc, cnt_apx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          id;
        logic [DW:0] d;
        logic        acc;
        int          ca;
        int          cx;
        int          due;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    int            ptr, mode, na, nx, idle_cyc, g;
    bit            busy, seen;
    logic [NR-1:0] exp_ready, last_ready;
    logic [DW-1:0] ga, gb;
    logic          gacc;

    conf_int_add_share_ctrl #(
        .NUM_REQ(NR), .DATA_PATH_BITWIDTH(DW), .OP_BITWIDTH(DW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_acc(req_acc),
        .add_a(add_a), .add_b(add_b), .add_acc_sel(add_acc_sel), .add_d(add_d),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_d(rsp_d), .rsp_acc(rsp_acc),
        .cnt_acc(cnt_acc), .cnt_apx(cnt_apx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder: full sum when accurate, low byte forced to zero when approximate.
    function automatic logic [DW:0] ref_sum(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic acc);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (!acc) s[7:0] = 8'h00;
        return s;
    endfunction

    assign add_d = ref_sum(add_a, add_b, add_acc_sel);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model and monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            ptr = NR - 1; mode = 1; na = 0; nx = 0;
            busy = 1'b0; seen = 1'b0; idle_cyc = 0; last_ready = '0;
        end else begin
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("rsp_spurious", 64'(rsp_valid), 64'(0));
                end else begin
                    e = q[0];
                    if (!seen) begin
                        check("rsp_latency", 64'(cyc), 64'(e.due));
                        seen = 1'b1;
                    end
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_d", 64'(rsp_d), 64'(e.d));
                    check("rsp_acc", 64'(rsp_acc), 64'(e.acc));
                    check("cnt_acc", 64'(cnt_acc), 64'(e.ca));
                    check("cnt_apx", 64'(cnt_apx), 64'(e.cx));
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                        busy = 1'b0;
                        idle_cyc = cyc + 1;
                    end
                end
            end
            exp_ready = '0;
            g = -1;
            if (!busy && cyc >= idle_cyc) begin
                for (int k = 1; k <= NR; k++) begin
                    if (g < 0 && req_valid[(ptr + k) % NR]) g = (ptr + k) % NR;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            last_ready = req_ready;
            if (g >= 0) begin
                ga   = req_a[g*DW +: DW];
                gb   = req_b[g*DW +: DW];
                gacc = req_acc[g];
                if (gacc) na++; else nx++;
                q.push_back('{g, ref_sum(ga, gb, gacc), gacc,
                              (na > CMAX) ? CMAX : na, (nx > CMAX) ? CMAX : nx,
                              cyc + ((int'(gacc) != mode) ? 3 : 2)});
                mode = int'(gacc);
                ptr  = g;
                busy = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (last_ready[i]) req_valid[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic acc);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_acc[i]        = acc;
        req_valid[i]      = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            step();
            if (req_valid == '0 && q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) check("drain_timeout", 64'(q.size()), 64'(0));
    endtask

    initial begin
        req_valid = '0; req_acc = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_add_acc_sel", 64'(add_acc_sel), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_add_a", 64'(add_a), 64'(0));
        check("rst_rsp_d", 64'(rsp_d), 64'(0));
        check("rst_cnt_acc", 64'(cnt_acc), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;

        // Same mode as reset: no settle cycle.
        step();
        set_req(0, 16'h0005, 16'h0003, 1'b1);
        wait_idle(20);
        check("t1_cnt_acc", 64'(cnt_acc), 64'(1));
        check("t1_rsp_d", 64'(rsp_d), 64'(17'h00008));

        // Mode change to approximate inserts a settle cycle.
        set_req(1, 16'h1234, 16'h0100, 1'b0);
        wait_idle(20);
        check("t2_cnt_apx", 64'(cnt_apx), 64'(1));
        check("t2_add_acc_sel", 64'(add_acc_sel), 64'(0));
        check("t2_rsp_d", 64'(rsp_d), 64'(17'h01300));

        // Everyone requesting in the current mode: rotation with 3-cycle spacing.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NR; i++) if (!req_valid[i]) set_req(i, rnd_op(), rnd_op(), 1'b0);
            step();
        end
        wait_idle(40);

        // Response back-pressure with requests pending.
        rsp_ready = 1'b0;
        set_req(2, 16'hABCD, 16'h1111, 1'b1);
        set_req(3, 16'h00FF, 16'h0001, 1'b1);
        repeat (9) step();
        @(negedge clk);
        check("stall_rsp_valid", 64'(rsp_valid), 64'(1));
        check("stall_rsp_id", 64'(rsp_id), 64'(2));
        rsp_ready = 1'b1;
        wait_idle(40);

        // Reset while the adder result is being captured.
        step();
        set_req(1, 16'h4444, 16'h2222, logic'(mode[0]));
        @(posedge clk);
        #2;
        req_valid = '0;
        rst = 1'b0;
        #1;
        check("exec_rst_add_acc_sel", 64'(add_acc_sel), 64'(1));
        check("exec_rst_add_a", 64'(add_a), 64'(0));
        check("exec_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("exec_rst_cnt_acc", 64'(cnt_acc), 64'(0));
        check("exec_rst_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, rnd_op(), rnd_op(), 1'b1);
        @(negedge clk);
        check("post_rst_first_grant", 64'(req_ready), 64'(4'b0001));
        wait_idle(60);

        // Drive accurate ops past the counter's all-ones value.
        for (int n = 0; n < CMAX + 4; n++) begin
            set_req(0, rnd_op(), rnd_op(), 1'b1);
            wait_idle(20);
        end
        check("sat_cnt_acc", 64'(cnt_acc), 64'(CMAX));

        // Random traffic with back-pressure and abandoned requests.
        for (int n = 0; n < 700; n++) begin
            step();
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, rnd_op(), rnd_op(), logic'($urandom_range(0, 1)));
            end
        end
        step();
        rsp_ready = 1'b1;
        req_valid = '0;
        wait_idle(60);
        check("final_cnt_apx", 64'(cnt_apx), 64'((nx > CMAX) ? CMAX : nx));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
